sram_stream_buf: RTL

- Parametrised successor to the 64x512b weight SRAM: generic width/depth, per-lane write mask, and a burst-read engine.
- The burst engine streams consecutive rows to the systolic-array feeder over a valid/ready handshake and tolerates backpressure without losing beats.
- Sits between the testbench/DMA loader (write side) and the PE-array input skew logic (read side).

---
 rtl/sram_stream_buf.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sram_stream_buf.sv
// Row-organised weight SRAM with per-lane write mask and a burst-read engine
// that streams consecutive rows over valid/ready through a 2-entry skid.
module sram_stream_buf #(
    parameter int DATA_WIDTH = 512,
    parameter int LANE_WIDTH = 16,
    parameter int DEPTH      = 64,
    localparam int LANES      = DATA_WIDTH / LANE_WIDTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb,
    input  logic                  wsb,
    input  logic [LANES-1:0]      wmask,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  burst_start,
    input  logic [ADDR_WIDTH-1:0] burst_addr,
    input  logic [ADDR_WIDTH:0]   burst_len,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = 0;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
    logic [ADDR_WIDTH:0]   issueLeft_q, issueLeft_d;
    logic                  pipeValid_q, pipeValid_d;
    logic                  pipeLast_q, pipeLast_d;
    logic [DATA_WIDTH-1:0] pipeData_q;
    logic                  headValid_q, headValid_d;
    logic                  headLast_q, headLast_d;
    logic [DATA_WIDTH-1:0] headData_q, headData_d;
    logic                  skidValid_q, skidValid_d;
    logic                  skidLast_q, skidLast_d;
    logic [DATA_WIDTH-1:0] skidData_q, skidData_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  issue;
    logic [1:0]            occAfterPop;

    // Array has no reset; the read register captures old data on a same-row write.
    always_ff @(posedge clk) begin
        if (!csb && !wsb) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem_q[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        if (issue) begin
            pipeData_q <= mem_q[rdAddr_q];
        end
    end

    assign pop         = headValid_q && rd_ready;
    assign occAfterPop = {1'b0, headValid_q} + {1'b0, skidValid_q} + {1'b0, pipeValid_q} - {1'b0, pop};
    // A read is only launched when the skid can absorb it even under full backpressure.
    assign issue       = (state_q == RUN) && (issueLeft_q != LEN_ZERO) && (occAfterPop < 2'd2);

    always_comb begin
        state_d     = state_q;
        rdAddr_d    = rdAddr_q;
        issueLeft_d = issueLeft_q;
        headValid_d = headValid_q;
        headLast_d  = headLast_q;
        headData_d  = headData_q;
        skidValid_d = skidValid_q;
        skidLast_d  = skidLast_q;
        skidData_d  = skidData_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pipeValid_d = issue;
        pipeLast_d  = issue && (issueLeft_q == LEN_ONE);

        if (issue) begin
            rdAddr_d    = rdAddr_q + ADDR_ONE;
            issueLeft_d = issueLeft_q - LEN_ONE;
        end

        if (!headValid_q || pop) begin
            if (skidValid_q) begin
                headValid_d = 1'b1;
                headLast_d  = skidLast_q;
                headData_d  = skidData_q;
                skidValid_d = pipeValid_q;
                if (pipeValid_q) begin
                    skidLast_d = pipeLast_q;
                    skidData_d = pipeData_q;
                end
            end else begin
                headValid_d = pipeValid_q;
                if (pipeValid_q) begin
                    headLast_d = pipeLast_q;
                    headData_d = pipeData_q;
                end
            end
        end else if (pipeValid_q) begin
            skidValid_d = 1'b1;
            skidLast_d  = pipeLast_q;
            skidData_d  = pipeData_q;
        end

        case (state_q)
            IDLE: begin
                if (burst_start) begin
                    if (burst_len != LEN_ZERO) begin
                        state_d     = RUN;
                        busy_d      = 1'b1;
                        rdAddr_d    = burst_addr;
                        issueLeft_d = burst_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pop && headLast_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rdAddr_q    <= '0;
            issueLeft_q <= '0;
            pipeValid_q <= 1'b0;
            pipeLast_q  <= 1'b0;
            headValid_q <= 1'b0;
            headLast_q  <= 1'b0;
            headData_q  <= '0;
            skidValid_q <= 1'b0;
            skidLast_q  <= 1'b0;
            skidData_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdAddr_q    <= rdAddr_d;
            issueLeft_q <= issueLeft_d;
            pipeValid_q <= pipeValid_d;
            pipeLast_q  <= pipeLast_d;
            headValid_q <= headValid_d;
            headLast_q  <= headLast_d;
            headData_q  <= headData_d;
            skidValid_q <= skidValid_d;
            skidLast_q  <= skidLast_d;
            skidData_q  <= skidData_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_valid = headValid_q;
    assign rd_last  = headLast_q;
    assign rdata    = headData_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
